// File: rtl/int_arb_pkg.sv
// Shared types and constants for the four-source interrupt arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package int_arb_pkg;

  localparam int NUM_SRC = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    WAIT_CLR = 2'd2
  } state_t;

  localparam logic [1:0] SRC_A = 2'd0;
  localparam logic [1:0] SRC_B = 2'd1;
  localparam logic [1:0] SRC_C = 2'd2;
  localparam logic [1:0] SRC_D = 2'd3;

  // Source after idx in round-robin order; 2-bit arithmetic wraps 3 -> 0.
  function automatic logic [1:0] next_src(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/int_arbiter4_rr_pick4.sv
// Winner picker for four requests: fixed priority (a highest) or round-robin from ptr.
// Latency: combinational, zero cycles.
// Backpressure: none; the result is valid whenever any is high.
//
// Ports:
//   req[3:0]    candidate requests (bit i = source i)
//   ptr[1:0]    round-robin start index, ignored when fixed=1
//   fixed       1 = lowest index wins, 0 = scan ptr, ptr+1, ... mod 4
//   onehot[3:0] one-hot winner, zero when no request
//   idx[1:0]    winner index, zero when no request
//   any         at least one request present
module rr_pick4
  import int_arb_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [1:0]         ptr,
  input  logic               fixed,
  output logic [NUM_SRC-1:0] onehot,
  output logic [1:0]         idx,
  output logic               any
);

  logic [1:0]         base;
  logic [1:0]         off;
  logic [NUM_SRC-1:0] rot;

  // Both policies share one rotate-then-priority-encode path; fixed priority
  // is simply a scan that always starts at source a.
  always_comb begin
    base   = fixed ? SRC_A : ptr;
    rot    = NUM_SRC'({req, req} >> base);
    off    = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (rot[k]) off = 2'(k);
    end
    any    = |req;
    idx    = any ? (base + off) : 2'd0;
    onehot = any ? (NUM_SRC'(1) << idx) : '0;
  end

endmodule

// File: rtl/int_arbiter4.sv
// Registered interrupt arbiter: four level requests -> one held one-hot grant plus irq.
// Latency: request captured at edge N, grant/irq registered at edge N+1.
// Backpressure: grant held until ack and the served request clears; others wait pending.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   m                       1 = fixed priority a>b>c>d, 0 = round-robin (sampled in IDLE)
//   int_a..int_d            level-sensitive requests
//   ack                     CPU acknowledge of the current grant
//   sa..sd, grant_id        registered one-hot select and index of the granted source
//   irq                     registered interrupt to the CPU side
//   tmo                     one-cycle pulse when a grant is abandoned on timeout
//   mask, pending           only with INT_ARB_MASK_EN: per-source mask and req_q & ~mask
//
// Optional feature macro: INT_ARB_MASK_EN.
module int_arbiter4
  import int_arb_pkg::*;
#(
  parameter int TIMEOUT = 0,
  parameter int TMO_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m,
  input  logic       int_a,
  input  logic       int_b,
  input  logic       int_c,
  input  logic       int_d,
  input  logic       ack,
  output logic       sa,
  output logic       sb,
  output logic       sc,
  output logic       sd,
  output logic [1:0] grant_id,
  output logic       irq,
  output logic       tmo
`ifdef INT_ARB_MASK_EN
  ,
  input  logic [NUM_SRC-1:0] mask,
  output logic [NUM_SRC-1:0] pending
`endif
);

  localparam bit               TMO_ON   = (TIMEOUT != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_ON ? TMO_W'(TIMEOUT - 1) : '0;

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] req_q;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] sel_q, sel_nxt;
  logic [1:0]         gid_q, gid_nxt;
  logic [1:0]         rr_ptr, rr_nxt;
  logic [TMO_W-1:0]   tmo_cnt, cnt_nxt;
  logic               irq_nxt, tmo_nxt;
  logic               own_req;

  logic [NUM_SRC-1:0] pick_oh;
  logic [1:0]         pick_idx;
  logic               pick_any;

  // Masking only affects who may win a new arbitration; an active grant
  // tracks the raw request so masking never revokes it.
`ifdef INT_ARB_MASK_EN
  assign elig = req_q & ~mask;
`else
  assign elig = req_q;
`endif

  rr_pick4 u_pick (
    .req    (elig),
    .ptr    (rr_ptr),
    .fixed  (m),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign own_req = req_q[gid_q];

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    gid_nxt   = gid_q;
    irq_nxt   = irq;
    tmo_nxt   = 1'b0;
    rr_nxt    = rr_ptr;
    cnt_nxt   = tmo_cnt;
    case (state)
      IDLE: begin
        sel_nxt = '0;
        irq_nxt = 1'b0;
        if (pick_any) begin
          sel_nxt   = pick_oh;
          gid_nxt   = pick_idx;
          irq_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        irq_nxt = 1'b1;
        // ack has priority over a same-cycle drop of the served request.
        if (ack) begin
          irq_nxt   = 1'b0;
          state_nxt = WAIT_CLR;
        end else if (!own_req) begin
          // Spurious request: abandon without moving the round-robin pointer.
          sel_nxt   = '0;
          irq_nxt   = 1'b0;
          state_nxt = IDLE;
        end else if (TMO_ON && (tmo_cnt == TMO_LAST)) begin
          sel_nxt   = '0;
          irq_nxt   = 1'b0;
          tmo_nxt   = 1'b1;
          rr_nxt    = next_src(gid_q);
          state_nxt = IDLE;
        end else begin
          cnt_nxt = tmo_cnt + TMO_W'(1);
        end
      end
      WAIT_CLR: begin
        // Select stays up so the datapath keeps routing until the source clears.
        irq_nxt = 1'b0;
        if (!own_req) begin
          sel_nxt   = '0;
          rr_nxt    = next_src(gid_q);
          state_nxt = IDLE;
        end
      end
      default: begin
        sel_nxt   = '0;
        irq_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      req_q   <= '0;
      sel_q   <= '0;
      gid_q   <= '0;
      irq     <= 1'b0;
      tmo     <= 1'b0;
      rr_ptr  <= '0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      req_q   <= {int_d, int_c, int_b, int_a};
      sel_q   <= sel_nxt;
      gid_q   <= gid_nxt;
      irq     <= irq_nxt;
      tmo     <= tmo_nxt;
      rr_ptr  <= rr_nxt;
      tmo_cnt <= cnt_nxt;
    end
  end

`ifdef INT_ARB_MASK_EN
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= req_q & ~mask;
  end
`endif

  assign {sd, sc, sb, sa} = sel_q;
  assign grant_id         = gid_q;

endmodule
